// File: rtl/bank_reader.sv
// Read-side stream engine for the 128x128 SRAM bank: turns an (addr, len) command into
// sequential bank reads and presents the rows on a valid/ready stream via a 2-entry skid FIFO.
module bank_reader #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned LEN_W  = 8
) (
    input  logic              vsi_clk,
    input  logic              vsi_reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              rd_cs,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } stateT;

    stateT             state;
    stateT             stateNext;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptrNext;
    logic [LEN_W-1:0]  rem;
    logic [LEN_W-1:0]  remNext;
    logic              inflight;
    logic              inflightLast;
    logic              issue;
    logic              pop;
    logic              push;
    logic [2:0]        occupancy;
    logic [1:0]        countAfterPop;

    logic [DATA_W-1:0] fifoData [2];
    logic [1:0]        fifoLast;
    logic              headIdx;
    logic              tailIdx;
    logic [1:0]        count;

    assign out_valid     = (count != 2'd0);
    assign pop           = out_valid && out_ready;
    assign push          = inflight;
    // Rows owned by the engine after this cycle's pop: stored plus the one arriving from the bank
    assign occupancy     = 3'(count) + 3'(inflight) - 3'(pop);
    assign countAfterPop = count - 2'(pop);

    assign cmd_ready = (state == IDLE);
    assign busy      = (state == RUN);
    assign done      = (state == FIN);
    assign rd_cs     = issue;
    assign rd_addr   = ptr;
    assign out_data  = fifoData[headIdx];
    assign out_last  = out_valid && fifoLast[headIdx];

    // Next-state, read issue and address/length bookkeeping
    always_comb begin
        stateNext = state;
        issue     = 1'b0;
        ptrNext   = ptr;
        remNext   = rem;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    ptrNext   = cmd_addr;
                    remNext   = cmd_len;
                    stateNext = (cmd_len == LEN_W'(0)) ? FIN : RUN;
                end
            end
            RUN: begin
                if ((rem != LEN_W'(0)) && (occupancy < 3'd2)) begin
                    issue   = 1'b1;
                    ptrNext = ptr + ADDR_W'(1);
                    remNext = rem - LEN_W'(1);
                end
                if ((rem == LEN_W'(0)) && !inflight && (countAfterPop == 2'd0)) begin
                    stateNext = FIN;
                end
            end
            FIN:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge vsi_clk or posedge vsi_reset) begin
        if (vsi_reset) begin
            state        <= IDLE;
            ptr          <= '0;
            rem          <= '0;
            inflight     <= 1'b0;
            inflightLast <= 1'b0;
        end else begin
            state        <= stateNext;
            ptr          <= ptrNext;
            rem          <= remNext;
            inflight     <= issue;
            inflightLast <= issue && (rem == LEN_W'(1));
        end
    end

    // Skid FIFO: bank data lands here one edge after issue, tagged with its last-row flag
    always_ff @(posedge vsi_clk or posedge vsi_reset) begin
        if (vsi_reset) begin
            fifoData[0] <= '0;
            fifoData[1] <= '0;
            fifoLast    <= '0;
            headIdx     <= 1'b0;
            tailIdx     <= 1'b0;
            count       <= '0;
        end else begin
            if (push) begin
                fifoData[tailIdx] <= rd_data;
                fifoLast[tailIdx] <= inflightLast;
                tailIdx           <= ~tailIdx;
            end
            if (pop) begin
                headIdx <= ~headIdx;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

endmodule
